// File: rtl/neuron_weight_server.sv
// Weight/bias responder for one neuron: stores a streamed bias+weight set and answers BRAM reads.
// Optional macro NEURON_WS_OUTREG_EN adds an output register stage (read latency 2 instead of 1).
module neuron_weight_server #(
   parameter int DATA_WIDTH = 16,
   parameter int DEPTH      = 64,
   parameter int ADDR_WIDTH = $clog2(DEPTH)
) (
   input  logic                  pi_clk,
   input  logic                  pi_rst,
   input  logic                  pi_load_start,
   input  logic                  pi_load_valid,
   input  logic [DATA_WIDTH-1:0] pi_load_data,
   output logic                  po_load_ready,
   output logic                  po_loaded,
   input  logic [ADDR_WIDTH-1:0] pi_BRAM_add,
   input  logic                  pi_BRAM_en,
   output logic [DATA_WIDTH-1:0] po_weights,
   output logic [DATA_WIDTH-1:0] po_bias,
   output logic                  po_valid,
   output logic                  po_clc_accumulator,
   output logic                  po_accumulation_done,
   output logic                  po_error
);
   typedef enum logic [1:0] {EMPTY, LOAD_BIAS, LOAD_W, READY} state_e;

   state_e                state_q;
   logic [ADDR_WIDTH-1:0] wptr_q;
   logic                  loaded_q, err_q;
   logic [DATA_WIDTH-1:0] bias_q;
   logic [DATA_WIDTH-1:0] mem_q [2**ADDR_WIDTH];

   logic                  rd_oob, rd_fire, wr_last, wr_en;
   logic [DATA_WIDTH-1:0] rdata_d;

   // Addresses beyond DEPTH only exist when DEPTH is not a power of two.
   if (DEPTH == 2**ADDR_WIDTH) begin : g_pow2
      assign rd_oob = 1'b0;
   end else begin : g_npow2
      assign rd_oob = (pi_BRAM_add >= ADDR_WIDTH'(DEPTH));
   end

   assign po_load_ready = (state_q == LOAD_BIAS) || (state_q == LOAD_W);
   assign wr_last       = (wptr_q == ADDR_WIDTH'(DEPTH - 1));
   assign wr_en         = (state_q == LOAD_W) && pi_load_valid && !pi_load_start;
   assign rd_fire       = pi_BRAM_en && (state_q == READY) && !pi_load_start;
   assign rdata_d       = rd_oob ? '0 : mem_q[pi_BRAM_add];
   assign po_loaded     = loaded_q;
   assign po_error      = err_q;
   assign po_bias       = bias_q;

   // A load start overrides everything else in the same cycle, including a read request.
   always_ff @(posedge pi_clk or negedge pi_rst) begin
      if (!pi_rst) begin
         state_q  <= EMPTY;
         wptr_q   <= '0;
         loaded_q <= 1'b0;
         err_q    <= 1'b0;
         bias_q   <= '0;
      end else if (pi_load_start) begin
         state_q  <= LOAD_BIAS;
         wptr_q   <= '0;
         loaded_q <= 1'b0;
         err_q    <= 1'b0;
      end else begin
         if (pi_BRAM_en && (state_q != READY || rd_oob)) err_q <= 1'b1;
         case (state_q)
            LOAD_BIAS: if (pi_load_valid) begin
               bias_q  <= pi_load_data;
               state_q <= LOAD_W;
            end
            LOAD_W: if (pi_load_valid) begin
               wptr_q <= wptr_q + 1'b1;
               if (wr_last) begin
                  state_q  <= READY;
                  loaded_q <= 1'b1;
               end
            end
            default: ;
         endcase
      end
   end

   always_ff @(posedge pi_clk) begin
      if (wr_en) mem_q[wptr_q] <= pi_load_data;
   end

   logic                  v1_q, c1_q, a1_q;
   logic [DATA_WIDTH-1:0] d1_q;

   always_ff @(posedge pi_clk or negedge pi_rst) begin
      if (!pi_rst) begin
         v1_q <= 1'b0;
         c1_q <= 1'b0;
         a1_q <= 1'b0;
         d1_q <= '0;
      end else begin
         v1_q <= rd_fire;
         c1_q <= rd_fire && (pi_BRAM_add == '0);
         a1_q <= rd_fire && (pi_BRAM_add == ADDR_WIDTH'(DEPTH - 1));
         if (rd_fire) d1_q <= rdata_d;
      end
   end

`ifdef NEURON_WS_OUTREG_EN
   logic                  v2_q, c2_q, a2_q;
   logic [DATA_WIDTH-1:0] d2_q;

   always_ff @(posedge pi_clk or negedge pi_rst) begin
      if (!pi_rst) begin
         v2_q <= 1'b0;
         c2_q <= 1'b0;
         a2_q <= 1'b0;
         d2_q <= '0;
      end else begin
         v2_q <= v1_q;
         c2_q <= c1_q;
         a2_q <= a1_q;
         if (v1_q) d2_q <= d1_q;
      end
   end

   assign po_valid             = v2_q;
   assign po_weights           = d2_q;
   assign po_clc_accumulator   = c2_q;
   assign po_accumulation_done = a2_q;
`else
   assign po_valid             = v1_q;
   assign po_weights           = d1_q;
   assign po_clc_accumulator   = c1_q;
   assign po_accumulation_done = a1_q;
`endif
endmodule

// File: tb/tb_neuron_weight_server.sv
// Bench for neuron_weight_server: DEPTH=4 and DEPTH=5 instances driven in parallel, checked
// every cycle against a word-count/schedule reference model; follows NEURON_WS_OUTREG_EN for latency.
module tb_neuron_weight_server;
`ifdef NEURON_WS_OUTREG_EN
   localparam int LAT = 2;
`else
   localparam int LAT = 1;
`endif
   localparam int DW = 16;

   logic clk = 1'b0, rst_n = 1'b1, start = 1'b0, lvalid = 1'b0, en = 1'b0;
   logic [DW-1:0] ldata = '0;
   logic [2:0]    addr = '0;
   logic [1:0]    ready, loaded, valid, clc, done, err;
   logic [1:0][DW-1:0] wts, bias;

   always #5 clk = ~clk;

   neuron_weight_server #(.DATA_WIDTH(DW), .DEPTH(4)) dut4 (
      .pi_clk(clk), .pi_rst(rst_n), .pi_load_start(start), .pi_load_valid(lvalid),
      .pi_load_data(ldata), .po_load_ready(ready[0]), .po_loaded(loaded[0]),
      .pi_BRAM_add(addr[1:0]), .pi_BRAM_en(en), .po_weights(wts[0]), .po_bias(bias[0]),
      .po_valid(valid[0]), .po_clc_accumulator(clc[0]), .po_accumulation_done(done[0]),
      .po_error(err[0]));

   neuron_weight_server #(.DATA_WIDTH(DW), .DEPTH(5)) dut5 (
      .pi_clk(clk), .pi_rst(rst_n), .pi_load_start(start), .pi_load_valid(lvalid),
      .pi_load_data(ldata), .po_load_ready(ready[1]), .po_loaded(loaded[1]),
      .pi_BRAM_add(addr), .pi_BRAM_en(en), .po_weights(wts[1]), .po_bias(bias[1]),
      .po_valid(valid[1]), .po_clc_accumulator(clc[1]), .po_accumulation_done(done[1]),
      .po_error(err[1]));

   int nchk = 0, nerr = 0, tcount = 0;

   // Reference model: word counter per instance plus a small response schedule indexed by cycle.
   bit            loading_m[2], loaded_m[2], err_m[2];
   int            cnt_m[2];
   logic [DW-1:0] bias_m[2];
   logic [DW-1:0] w_m[2][8];
   bit            sv[2][4], sc[2][4], sdn[2][4];
   logic [DW-1:0] sd[2][4];
   bit            ev[2], ec[2], edn[2];
   logic [DW-1:0] ed[2];

   function automatic logic [37:0] act(int i);
      return {valid[i], wts[i], clc[i], done[i], err[i], loaded[i], ready[i], bias[i]};
   endfunction

   function automatic logic [37:0] expv(int i);
      return {ev[i], ed[i], ec[i], edn[i], err_m[i], loaded_m[i], loading_m[i], bias_m[i]};
   endfunction

   task automatic model_reset();
      for (int i = 0; i < 2; i++) begin
         loading_m[i] = 0; loaded_m[i] = 0; err_m[i] = 0; cnt_m[i] = 0; bias_m[i] = '0;
         ev[i] = 0; ec[i] = 0; edn[i] = 0; ed[i] = '0;
         for (int s = 0; s < 4; s++) begin sv[i][s] = 0; sc[i][s] = 0; sdn[i][s] = 0; sd[i][s] = '0; end
      end
   endtask

   task automatic tick();
      logic s, lv, e;
      logic [DW-1:0] ld;
      logic [2:0] a;
      s = start; lv = lvalid; ld = ldata; e = en; a = addr;
      @(posedge clk);
      tcount++;
      for (int i = 0; i < 2; i++) begin
         int d, aa, sl;
         d  = (i == 0) ? 4 : 5;
         aa = (i == 0) ? int'(a[1:0]) : int'(a);
         if (e && !s) begin
            if (loaded_m[i]) begin
               sl = (tcount + LAT - 1) % 4;
               sv[i][sl]  = 1;
               sd[i][sl]  = (aa < d) ? w_m[i][aa] : '0;
               sc[i][sl]  = (aa == 0);
               sdn[i][sl] = (aa == d - 1);
               if (aa >= d) err_m[i] = 1;
            end else err_m[i] = 1;
         end
         if (s) begin
            loading_m[i] = 1; cnt_m[i] = 0; loaded_m[i] = 0; err_m[i] = 0;
         end else if (loading_m[i] && lv) begin
            if (cnt_m[i] == 0) bias_m[i] = ld; else w_m[i][cnt_m[i]-1] = ld;
            cnt_m[i]++;
            if (cnt_m[i] == d + 1) begin loading_m[i] = 0; loaded_m[i] = 1; end
         end
         sl = tcount % 4;
         ev[i]  = sv[i][sl];
         ec[i]  = sv[i][sl] && sc[i][sl];
         edn[i] = sv[i][sl] && sdn[i][sl];
         if (sv[i][sl]) ed[i] = sd[i][sl];
         sv[i][sl] = 0;
      end
      #1;
   endtask

   task automatic load_words(input logic [DW-1:0] w0, w1, w2, w3, w4, w5);
      logic [DW-1:0] ws[6];
      ws = '{w0, w1, w2, w3, w4, w5};
      for (int k = 0; k < 6; k++) begin lvalid = 1; ldata = ws[k]; tick(); end
      lvalid = 0;
   endtask

   task automatic test_reset();
      #1 rst_n = 0;
      model_reset();
      #2;
      for (int i = 0; i < 2; i++) begin
         nchk++;
         if (act(i) !== 38'd0) begin nerr++; $display("FAIL reset_state d%0d: got %h want 0", i, act(i)); end
      end
      @(negedge clk) rst_n = 1;
      tick();
      for (int i = 0; i < 2; i++) begin
         nchk++;
         if (act(i) !== expv(i)) begin nerr++; $display("FAIL reset_release d%0d: got %h want %h", i, act(i), expv(i)); end
      end
   endtask

   task automatic test_load();
      logic [DW-1:0] ws[7];
      logic          vs[7];
      ws = '{16'h0005, 16'h0001, 16'h0002, 16'h0000, 16'h0003, 16'h0004, 16'h0006};
      vs = '{1'b1, 1'b1, 1'b1, 1'b0, 1'b1, 1'b1, 1'b1};
      start = 1; tick(); start = 0;
      for (int i = 0; i < 2; i++) begin
         nchk++;
         if (act(i) !== expv(i)) begin nerr++; $display("FAIL load_start d%0d: got %h want %h", i, act(i), expv(i)); end
      end
      for (int k = 0; k < 7; k++) begin
         lvalid = vs[k]; ldata = ws[k]; tick();
         for (int i = 0; i < 2; i++) begin
            nchk++;
            if (act(i) !== expv(i)) begin nerr++; $display("FAIL load_word%0d d%0d: got %h want %h", k, i, act(i), expv(i)); end
         end
         if (k == 5) begin
            nchk++;
            if ({loaded[0], ready[0], bias[0]} !== {1'b1, 1'b0, 16'h0005}) begin
               nerr++; $display("FAIL load_done4: got loaded=%b ready=%b bias=%h want 1 0 0005", loaded[0], ready[0], bias[0]);
            end
         end
      end
      lvalid = 0;
   endtask

   task automatic test_read();
      int first_k = -1, nv = 0;
      logic [DW-1:0] got[8];
      logic [7:0]    gc = '0, gd = '0;
      for (int k = 1; k <= 4 + LAT + 1; k++) begin
         en = (k <= 4); addr = 3'(k - 1);
         tick();
         for (int i = 0; i < 2; i++) begin
            nchk++;
            if (act(i) !== expv(i)) begin nerr++; $display("FAIL read_cyc%0d d%0d: got %h want %h", k, i, act(i), expv(i)); end
         end
         if (valid[0] === 1'b1) begin
            if (first_k < 0) first_k = k;
            got[nv] = wts[0]; gc[nv] = clc[0]; gd[nv] = done[0]; nv++;
         end
      end
      en = 0;
      nchk++;
      if (first_k != LAT || nv != 4) begin nerr++; $display("FAIL read_latency: got first=%0d n=%0d want first=%0d n=4", first_k, nv, LAT); end
      nchk++;
      if ({got[0], got[1], got[2], got[3]} !== {16'd1, 16'd2, 16'd3, 16'd4} || gc[3:0] !== 4'b0001 || gd[3:0] !== 4'b1000) begin
         nerr++; $display("FAIL read_data: got %h %h %h %h clc=%b done=%b want 1 2 3 4 0001 1000", got[0], got[1], got[2], got[3], gc[3:0], gd[3:0]);
      end
      nchk++;
      if (wts[0] !== 16'd4 || err !== 2'b00) begin nerr++; $display("FAIL read_hold: got w=%h err=%b want 0004 00", wts[0], err); end
   endtask

   task automatic test_oob();
      logic [DW-1:0] w5 = 16'hffff;
      logic          v5 = 1'b0;
      for (int k = 0; k < 3 + LAT; k++) begin
         en = (k < 2); addr = (k == 0) ? 3'd6 : 3'd4;
         tick();
         for (int i = 0; i < 2; i++) begin
            nchk++;
            if (act(i) !== expv(i)) begin nerr++; $display("FAIL oob_cyc%0d d%0d: got %h want %h", k, i, act(i), expv(i)); end
         end
         if (k == LAT - 1) begin v5 = valid[1]; w5 = wts[1]; end
      end
      en = 0;
      nchk++;
      if (v5 !== 1'b1 || w5 !== 16'd0 || err[1] !== 1'b1 || err[0] !== 1'b0) begin
         nerr++; $display("FAIL oob_resp: got v=%b w=%h err=%b want 1 0000 err=10", v5, w5, err);
      end
      start = 1; tick(); start = 0;
      nchk++;
      if (err !== 2'b00 || ready !== 2'b11) begin nerr++; $display("FAIL oob_clear: got err=%b ready=%b want 00 11", err, ready); end
   endtask

   task automatic test_collision();
      load_words(16'h1111, 16'ha0, 16'ha1, 16'ha2, 16'ha3, 16'ha4);
      en = 1; addr = 3'd2; start = 1;
      tick();
      en = 0; start = 0;
      nchk++;
      if (loaded !== 2'b00 || ready !== 2'b11) begin nerr++; $display("FAIL coll_state: got loaded=%b ready=%b want 00 11", loaded, ready); end
      for (int k = 0; k < LAT + 1; k++) begin
         if (k > 0) tick();
         for (int i = 0; i < 2; i++) begin
            nchk++;
            if (act(i) !== expv(i) || valid[i] !== 1'b0) begin
               nerr++; $display("FAIL coll_cyc%0d d%0d: got %h want %h (no response)", k, i, act(i), expv(i));
            end
         end
      end
   endtask

   task automatic test_reset_midload();
      lvalid = 1; ldata = 16'h0bb0; tick();
      ldata = 16'h0001; tick();
      ldata = 16'h0002; tick();
      lvalid = 0;
      #2 rst_n = 0;
      model_reset();
      #1;
      for (int i = 0; i < 2; i++) begin
         nchk++;
         if (act(i) !== 38'd0) begin nerr++; $display("FAIL midrst_async d%0d: got %h want 0", i, act(i)); end
      end
      @(posedge clk); #1;
      nchk++;
      if ({act(0), act(1)} !== 76'd0) begin nerr++; $display("FAIL midrst_hold: got %h %h want 0", act(0), act(1)); end
      @(negedge clk) rst_n = 1;
      en = 1; addr = 3'd1; tick(); en = 0;
      for (int i = 0; i < 2; i++) begin
         nchk++;
         if (act(i) !== expv(i) || err[i] !== 1'b1 || valid[i] !== 1'b0) begin
            nerr++; $display("FAIL midrst_read d%0d: got %h want %h (err=1)", i, act(i), expv(i));
         end
      end
   endtask

   task automatic test_random();
      start = 1; tick(); start = 0;
      for (int k = 0; k < 1500; k++) begin
         start  = ($urandom_range(0, 59) == 0);
         lvalid = 1'($urandom_range(0, 1));
         ldata  = 16'($urandom);
         en     = ($urandom_range(0, 2) != 0);
         addr   = ($urandom_range(0, 7) == 0) ? 3'($urandom_range(5, 7)) : 3'($urandom_range(0, 4));
         tick();
         for (int i = 0; i < 2; i++) begin
            nchk++;
            if (act(i) !== expv(i)) begin nerr++; $display("FAIL random_cyc%0d d%0d: got %h want %h", k, i, act(i), expv(i)); end
         end
      end
      start = 0; lvalid = 0; en = 0;
   endtask

   initial begin
      model_reset();
      test_reset();
      test_load();
      test_read();
      test_oob();
      test_collision();
      test_reset_midload();
      test_random();
      $display("Simulation finished: %0d checks, %0d errors", nchk, nerr);
      $finish;
   end
endmodule
